tt_lut_eval: RTL and testbench

Parametrised, reprogrammable truth-table evaluator: the runtime-loadable successor to the fixed 4-input gate netlists generated per hex truth table. Holds one 2^N_IN-bit truth table per output channel and evaluates all channels against a streamed input vector, with registered, back-pressurable output. Tables are reloaded through a narrow configuration stream into a shadow buffer and committed atomically, so evaluation never sees a partially written table.

---
 rtl/tt_pkg.sv | 30 +++
 rtl/tt_cfg_loader.sv | 111 +++++++++++
 rtl/tt_lut_eval.sv | 96 +++++++++
 tb/tb_tt_lut_eval.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table evaluator: table geometry helpers,
// configuration FSM states and the default reset table.
package tt_pkg;

  typedef enum logic [1:0] {
    TT_IDLE   = 2'd0,
    TT_LOAD   = 2'd1,
    TT_COMMIT = 2'd2
  } tt_state_e;

  localparam logic [15:0] TT_INIT_DEFAULT = 16'h10C9;

  function automatic int tt_depth(input int n_in);
    return 32'sd1 << n_in;
  endfunction

  function automatic int tt_seg_count(input int n_in, input int cfg_w);
    return tt_depth(n_in) / cfg_w;
  endfunction

  // Beat counter must hold at least one bit even for single-beat tables.
  function automatic int tt_cnt_w(input int n_in, input int cfg_w);
    return (tt_seg_count(n_in, cfg_w) > 1) ? $clog2(tt_seg_count(n_in, cfg_w)) : 1;
  endfunction

  function automatic int tt_ch_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/tt_cfg_loader.sv
// Configuration stream receiver: gathers table segments into a shadow word and
// presents it for a one-cycle atomic commit into the selected channel.
module tt_cfg_loader
  import tt_pkg::*;
#(
  parameter  int N_IN  = 4,
  parameter  int N_CH  = 2,
  parameter  int CFG_W = 4,
  localparam int TBL_W = tt_depth(N_IN),
  localparam int CH_W  = tt_ch_w(N_CH),
  localparam int SEG_N = tt_seg_count(N_IN, CFG_W),
  localparam int CNT_W = tt_cnt_w(N_IN, CFG_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             busy,
  output logic             commit,
  output logic [CH_W-1:0]  commit_ch,
  output logic [TBL_W-1:0] commit_word
);

  localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(SEG_N - 1);
  localparam logic [CH_W:0]    N_CH_L   = (CH_W + 1)'(N_CH);

  tt_state_e          state_r;
  tt_state_e          state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_s;
  logic [CNT_W-1:0]   seg_s;
  logic [TBL_W-1:0]   shadow_r;
  logic [CH_W-1:0]    ch_r;
  logic               ch_ok_r;
  logic               cfg_ready_r;
  logic               busy_r;
  logic               beat_s;

  assign beat_s = cfg_valid & cfg_ready_r;

  // Next-state and beat-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    seg_s   = cnt_r;
    case (state_r)
      TT_IDLE: begin
        seg_s = {CNT_W{1'b0}};
        if (beat_s) begin
          cnt_s   = CNT_W'(1);
          state_s = (SEG_N == 1) ? TT_COMMIT : TT_LOAD;
        end else begin
          state_s = TT_IDLE;
        end
      end
      TT_LOAD: begin
        if (beat_s && (cnt_r == LAST_SEG)) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = TT_COMMIT;
        end else if (beat_s) begin
          cnt_s = cnt_r + CNT_W'(1);
        end else begin
          state_s = TT_LOAD;
        end
      end
      TT_COMMIT: begin
        cnt_s   = {CNT_W{1'b0}};
        state_s = TT_IDLE;
      end
      default: begin
        cnt_s   = {CNT_W{1'b0}};
        state_s = TT_IDLE;
      end
    endcase
  end

  // State, shadow buffer and latched channel; handshake flags follow next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= TT_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      shadow_r    <= {TBL_W{1'b0}};
      ch_r        <= {CH_W{1'b0}};
      ch_ok_r     <= 1'b0;
      cfg_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      cfg_ready_r <= (state_s != TT_COMMIT);
      busy_r      <= (state_s != TT_IDLE);
      if (beat_s) begin
        shadow_r[seg_s*CFG_W +: CFG_W] <= cfg_data;
      end
      // Out-of-range channels still run the full load but never commit.
      if (beat_s && (state_r == TT_IDLE)) begin
        ch_r    <= cfg_ch;
        ch_ok_r <= ({1'b0, cfg_ch} < N_CH_L);
      end
    end
  end

  assign cfg_ready   = cfg_ready_r;
  assign busy        = busy_r;
  assign commit      = (state_r == TT_COMMIT) & ch_ok_r;
  assign commit_ch   = ch_r;
  assign commit_word = shadow_r;

endmodule

// File: rtl/tt_lut_eval.sv
// Reprogrammable truth-table evaluator: per-channel table store, lookup mux and
// a single back-pressurable output register.
module tt_lut_eval
  import tt_pkg::*;
#(
  parameter  int                        N_IN  = 4,
  parameter  int                        N_CH  = 2,
  parameter  int                        CFG_W = 4,
  parameter  logic [tt_depth(N_IN)-1:0] INIT  = tt_depth(N_IN)'(TT_INIT_DEFAULT),
  localparam int                        TBL_W = tt_depth(N_IN),
  localparam int                        CH_W  = tt_ch_w(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CFG_W-1:0] cfg_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_CH-1:0]  out_bits,
  output logic             tt_busy
);

  logic [TBL_W-1:0] tbl_r [N_CH];
  logic             commit_s;
  logic [CH_W-1:0]  commit_ch_s;
  logic [TBL_W-1:0] commit_word_s;
  logic [N_CH-1:0]  eval_s;
  logic [N_CH-1:0]  out_bits_r;
  logic             out_valid_r;
  logic             in_ready_s;

  tt_cfg_loader #(
    .N_IN  (N_IN),
    .N_CH  (N_CH),
    .CFG_W (CFG_W)
  ) u_loader (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_data    (cfg_data),
    .busy        (tt_busy),
    .commit      (commit_s),
    .commit_ch   (commit_ch_s),
    .commit_word (commit_word_s)
  );

  // Table store; a commit replaces one whole channel in a single edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        tbl_r[c] <= INIT;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (commit_s && (commit_ch_s == CH_W'(c))) begin
          tbl_r[c] <= commit_word_s;
        end
      end
    end
  end

  // Lookup of every channel at the requested index.
  always_comb begin
    eval_s = {N_CH{1'b0}};
    for (int c = 0; c < N_CH; c++) begin
      eval_s[c] = tbl_r[c][in_vec];
    end
  end

  assign in_ready_s = ~out_valid_r | out_ready;

  // Output register: accept overrides consume so a full pipe streams one per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_bits_r  <= {N_CH{1'b0}};
    end else if (in_valid && in_ready_s) begin
      out_valid_r <= 1'b1;
      out_bits_r  <= eval_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_bits  = out_bits_r;

endmodule

// File: tb/tb_tt_lut_eval.sv
// Directed bench for tt_lut_eval (three channels so an out-of-range channel
// code exists), with a transaction-level model checked every cycle.
module tb_tt_lut_eval;

  localparam int NCH = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = 2'd0;
  logic [3:0] cfg_data = 4'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_vec = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] out_bits;
  logic       tt_busy;

  int n_cmp = 0;
  int n_bad = 0;

  tt_lut_eval #(.N_IN(4), .N_CH(NCH), .CFG_W(4), .INIT(16'h10C9)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .tt_busy(tt_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: tables as plain words, a config transaction as a list of beats
  // followed by one commit cycle, and one output slot.
  logic [15:0] m_tbl [NCH];
  logic [15:0] m_shadow;
  logic [1:0]  m_ch;
  int          m_beats;
  bit          m_pend;
  bit          m_valid;
  logic [2:0]  m_bits;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) m_tbl[c] = 16'h10C9;
    m_shadow = 16'h0000;
    m_ch     = 2'd0;
    m_beats  = 0;
    m_pend   = 1'b0;
    m_valid  = 1'b0;
    m_bits   = 3'b000;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        if (in_valid && (!m_valid || out_ready)) begin
          for (int c = 0; c < NCH; c++) m_bits[c] = m_tbl[c][in_vec];
          m_valid = 1'b1;
        end else if (out_ready) begin
          m_valid = 1'b0;
        end
        if (m_pend) begin
          if (int'(m_ch) < NCH) m_tbl[m_ch] = m_shadow;
          m_pend = 1'b0;
        end else if (cfg_valid) begin
          if (m_beats == 0) m_ch = cfg_ch;
          m_shadow[m_beats*4 +: 4] = cfg_data;
          m_beats++;
          if (m_beats == 4) begin
            m_pend  = 1'b1;
            m_beats = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("cfg_ready", cfg_ready, !m_pend);
      chk("tt_busy", tt_busy, m_pend || (m_beats != 0));
      chk("out_valid", out_valid, m_valid);
      chk("in_ready", in_ready, !m_valid || out_ready);
      if (m_valid) chk("out_bits", out_bits, m_bits);
    end
  end

  task automatic eval_one(input logic [3:0] v, input logic [2:0] exp);
    @(negedge clk);
    in_valid = 1'b1; in_vec = v; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("eval_valid", out_valid, 1'b1);
    chk("eval_bits", out_bits, exp);
  endtask

  task automatic cfg_load(input int ch, input logic [15:0] word, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      @(negedge clk);
      cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_data = word[k*4 +: 4];
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    if (nbeats == 4) begin
      #1;
      chk("commit_cfg_ready", cfg_ready, 1'b0);
      chk("commit_busy", tt_busy, 1'b1);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_bits", out_bits, 3'b000);
    chk("rst_busy", tt_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // INIT 'h10C9 on every channel
    eval_one(4'd0,  3'b111);
    eval_one(4'd1,  3'b000);
    eval_one(4'd3,  3'b111);
    eval_one(4'd12, 3'b111);
    eval_one(4'd15, 3'b000);

    cfg_load(1, 16'hFFFF, 4);
    @(negedge clk);
    #1;
    chk("post_commit_ready", cfg_ready, 1'b1);
    chk("post_commit_busy", tt_busy, 1'b0);
    eval_one(4'd1, 3'b010);

    // continuous requests across a commit of ch2 <= 0
    @(negedge clk);
    in_valid = 1'b1; in_vec = 4'd0; out_ready = 1'b1;
    cfg_load(2, 16'h0000, 4);
    @(negedge clk);
    #1;
    chk("commit_edge_old", out_bits, 3'b111);
    @(negedge clk);
    #1;
    chk("after_commit_new", out_bits, 3'b011);
    in_valid = 1'b0;

    // backpressure
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_vec = 4'd3; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_vec = 4'(i * 3 + 5);
      #1;
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_hold", out_bits, 3'b011);
    end
    @(negedge clk);
    out_ready = 1'b1; in_vec = 4'd12;
    @(negedge clk);
    in_vec = 4'd15;
    #1;
    chk("stream_12", out_bits, 3'b011);
    @(negedge clk);
    in_vec = 4'd0;
    #1;
    chk("stream_15", out_bits, 3'b010);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("stream_0", out_bits, 3'b011);

    // out-of-range channel: full load accepted, no table changes
    cfg_load(3, 16'h0000, 4);
    eval_one(4'd0,  3'b011);
    eval_one(4'd15, 3'b010);

    // reset in the middle of a load, with a held result in the output register
    @(negedge clk);
    in_valid = 1'b1; in_vec = 4'd3; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cfg_load(1, 16'h0000, 2);
    #1;
    chk("midload_busy", tt_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", tt_busy, 1'b0);
    chk("midrst_cfg_ready", cfg_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    eval_one(4'd1, 3'b000);
    eval_one(4'd0, 3'b111);
    cfg_load(0, 16'hFFFF, 4);
    eval_one(4'd1, 3'b001);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
